reduction_epoch_controller: RTL



---
 rtl/reduction_epoch_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/reduction_epoch_controller.sv
// Epoch sequencer for the reduction tree: admits one flit per participating source,
// then counts drained result flits until completion or timeout.
//   state   | meaning
//   IDLE    | waiting for start
//   COLLECT | admitting one flit per masked source
//   DRAIN   | all flits admitted, counting result flits
//   DONE    | one-cycle epoch end report
module reduction_epoch_controller #(
  parameter int FAN_IN         = 54,
  parameter int OUT_PER_EPOCH  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FAN_IN-1:0] part_mask,
  input  logic [FAN_IN-1:0] src_valid,
  output logic [FAN_IN-1:0] src_avail,
  output logic [FAN_IN-1:0] tree_in_valid,
  input  logic [FAN_IN-1:0] tree_in_avail,
  input  logic              tree_out_valid,
  input  logic              sink_avail,
  output logic              busy,
  output logic              epoch_done,
  output logic              epoch_err,
  output logic              timeout_sticky,
  output logic [7:0]        epoch_id
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  localparam logic [8:0]  OUT_TGT  = 9'(OUT_PER_EPOCH);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nx;
  logic [FAN_IN-1:0] mask_r, seen, open_v, accept;
  logic [7:0]        out_cnt;
  logic [15:0]       tmo_cnt;
  logic              err_r, sticky_r;
  logic              active, fire, mask_full, out_full, tmo_hit, tmo_evt;
  logic [8:0]        out_sum;

  assign open_v        = (state == COLLECT) ? (mask_r & ~seen) : '0;
  assign tree_in_valid = src_valid & open_v;
  assign src_avail     = tree_in_avail & open_v;
  assign accept        = src_valid & tree_in_avail & open_v;

  assign active    = (state == COLLECT) || (state == DRAIN);
  assign fire      = active & tree_out_valid & sink_avail;
  assign out_sum   = {1'b0, out_cnt} + {8'd0, fire};
  // >= rather than == so surplus early outputs cannot strand the epoch in DRAIN
  assign out_full  = out_sum >= OUT_TGT;
  assign mask_full = (seen | accept) == mask_r;
  assign tmo_hit   = tmo_cnt == TMO_LAST;

  always_comb begin
    state_nx = state;
    tmo_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (part_mask == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        if (mask_full && out_full) state_nx = DONE;
        else if (tmo_hit) begin
          state_nx = DONE;
          tmo_evt  = 1'b1;
        end
        else if (mask_full) state_nx = DRAIN;
      end
      DRAIN: begin
        if (out_full) state_nx = DONE;
        else if (tmo_hit) begin
          state_nx = DONE;
          tmo_evt  = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mask_r   <= '0;
      seen     <= '0;
      out_cnt  <= '0;
      tmo_cnt  <= '0;
      err_r    <= 1'b0;
      sticky_r <= 1'b0;
      epoch_id <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            mask_r  <= part_mask;
            seen    <= '0;
            out_cnt <= '0;
            tmo_cnt <= '0;
            err_r   <= 1'b0;
          end
        end
        COLLECT, DRAIN: begin
          seen    <= seen | accept;
          tmo_cnt <= tmo_cnt + 16'd1;
          if (fire && (out_cnt != 8'hFF)) out_cnt <= out_cnt + 8'd1;
          if (tmo_evt) begin
            err_r    <= 1'b1;
            sticky_r <= 1'b1;
          end
        end
        DONE:    epoch_id <= epoch_id + 8'd1;
        default: ;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign epoch_done     = (state == DONE);
  assign epoch_err      = (state == DONE) & err_r;
  assign timeout_sticky = sticky_r;

endmodule
